// File: rtl/edit_mem_buf_release_mc.sv
// Multi-channel buffer-release tracker for the edit-memory buffer pool.
// Buffers are registered with an expected read count. Reader channels and an
// internal zero-read FIFO post releases through a 4-stage read/modify/write
// pipeline. A buffer is freed to the allocator once every expected read has
// been released.
`ifndef EM_BUF_PTR_NBITS
`define EM_BUF_PTR_NBITS 6
`endif
`ifndef READ_COUNT_NBITS
`define READ_COUNT_NBITS 4
`endif

module edit_mem_buf_release_mc #(
  parameter int BPTR_NBITS  = `EM_BUF_PTR_NBITS,
  parameter int RC_NBITS    = `READ_COUNT_NBITS,
  parameter int NUM_CH      = 4,
  parameter int ZFIFO_DEPTH = 4,
  parameter int OUT_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         read_count_valid,
  input  logic [BPTR_NBITS-1:0]        read_count_buf_ptr,
  input  logic [RC_NBITS-1:0]          read_count,
  output logic                         zfifo_full,
  input  logic [NUM_CH-1:0]            rel_req_valid,
  input  logic [NUM_CH*BPTR_NBITS-1:0] rel_req_ptr,
  output logic [NUM_CH-1:0]            rel_req_ready,
  output logic                         rel_buf_valid,
  output logic [BPTR_NBITS-1:0]        rel_buf_ptr,
  input  logic                         rel_buf_ready,
  output logic                         rel_err_valid,
  output logic [BPTR_NBITS-1:0]        rel_err_ptr
);
  localparam int DEPTH  = 1 << BPTR_NBITS;
  localparam int STAGES = 3;
  localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ZAW    = $clog2(ZFIFO_DEPTH);
  localparam int ZCW    = ZAW + 1;
  localparam int OAW    = $clog2(OUT_DEPTH);
  localparam int OCW    = OAW + 1;

  typedef logic [BPTR_NBITS-1:0] ptr_t;
  typedef struct packed {
    logic                alloc;
    logic [RC_NBITS-1:0] cnt;
  } ctr_t;
  localparam ctr_t CTR_NEW  = '{alloc: 1'b1, cnt: '0};
  localparam ctr_t CTR_FREE = '{alloc: 1'b0, cnt: '0};

  // limit = R-1 so the match compare is cnt==limit on the Nth release
  logic [RC_NBITS-1:0] lim_ram [DEPTH];
  ctr_t                ctr_ram [DEPTH];

  logic                reg_v;
  ptr_t                reg_ptr;
  logic [RC_NBITS-1:0] reg_rc, reg_lim;

  ptr_t           zmem [ZFIFO_DEPTH];
  logic [ZAW-1:0] z_wr, z_rd;
  logic [ZCW-1:0] z_cnt;
  logic           z_push, z_pop;

  ptr_t           omem [OUT_DEPTH];
  logic [OAW-1:0] o_wr, o_rd;
  logic [OCW-1:0] o_cnt;
  logic           o_push, o_pop;

  logic              arb_en, credit_ok, gnt_any, z_gnt;
  logic [CHW-1:0]    rr_ptr, rr_nxt;
  logic [NUM_CH-1:0] ch_gnt;
  ptr_t              gnt_ptr;
  int                gnt_idx;

  logic [STAGES:1]     vld_pipe;
  ptr_t                s1_ptr, s2_ptr, s3_ptr;
  ctr_t                s2_ctr, s3_ctr, s1_ctr_fwd, s2_ctr_fwd, s3_wdata;
  logic [RC_NBITS-1:0] s2_lim, s3_lim, s1_lim_fwd, s2_lim_fwd;
  logic                s3_we, s3_free, s3_err;

  // Input registration stage for buffer registrations
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reg_v   <= 1'b0;
      reg_ptr <= '0;
      reg_rc  <= '0;
    end else begin
      reg_v   <= read_count_valid;
      reg_ptr <= read_count_buf_ptr;
      reg_rc  <= read_count;
    end
  end

  assign reg_lim = (reg_rc == '0) ? '0 : reg_rc - 1'b1;
  assign z_push  = reg_v && (reg_rc == '0);
  assign z_pop   = z_gnt;
  // Counts the registration still in the input register so the source stops in time
  assign zfifo_full = (int'(z_cnt) + int'(z_push)) >= ZFIFO_DEPTH;

  // Tracker RAM writes; a registration to the S3 pointer has already masked s3_we
  always_ff @(posedge clk) begin
    if (s3_we) ctr_ram[s3_ptr] <= s3_wdata;
    if (reg_v) begin
      ctr_ram[reg_ptr] <= CTR_NEW;
      lim_ram[reg_ptr] <= reg_lim;
    end
  end

  // Zero-read self-release FIFO storage
  always_ff @(posedge clk) begin
    if (z_push) zmem[z_wr] <= reg_ptr;
  end

  // Zero-read FIFO pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      z_wr  <= '0;
      z_rd  <= '0;
      z_cnt <= '0;
    end else begin
      z_wr  <= z_wr + ZAW'(z_push);
      z_rd  <= z_rd + ZAW'(z_pop);
      z_cnt <= z_cnt + ZCW'(z_push) - ZCW'(z_pop);
    end
  end

  // Credit: every in-flight event may end in an out-FIFO push
  assign credit_ok = arb_en && (($countones(vld_pipe) + int'(o_cnt)) < OUT_DEPTH);

  // Arbitration: zero-read FIFO first, then round-robin over the channels
  always_comb begin
    int idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    z_gnt   = 1'b0;
    ch_gnt  = '0;
    gnt_idx = 0;
    gnt_ptr = '0;
    if (credit_ok) begin
      if (z_cnt != '0) begin
        z_gnt   = 1'b1;
        gnt_ptr = zmem[z_rd];
      end else begin
        for (int off = 0; off < NUM_CH; off++) begin
          idx = int'(rr_ptr) + off;
          if (idx >= NUM_CH) idx = idx - NUM_CH;
          if (!found && rel_req_valid[idx]) begin
            found       = 1'b1;
            ch_gnt[idx] = 1'b1;
            gnt_idx     = idx;
            gnt_ptr     = rel_req_ptr[idx*BPTR_NBITS +: BPTR_NBITS];
          end
        end
      end
    end
    gnt_any = z_gnt || (ch_gnt != '0);
    rr_nxt  = (gnt_idx == NUM_CH - 1) ? '0 : CHW'(gnt_idx + 1);
  end

  assign rel_req_ready = ch_gnt;

  // Arbiter enable (keeps ready low through reset) and round-robin pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      arb_en <= 1'b0;
      rr_ptr <= '0;
    end else begin
      arb_en <= 1'b1;
      if (ch_gnt != '0) rr_ptr <= rr_nxt;
    end
  end

  // Read-data forwarding from writes landing on the same edge as each capture
  always_comb begin
    s1_ctr_fwd = ctr_ram[s1_ptr];
    s1_lim_fwd = lim_ram[s1_ptr];
    if (s3_we && s3_ptr == s1_ptr) s1_ctr_fwd = s3_wdata;
    if (reg_v && reg_ptr == s1_ptr) begin
      s1_ctr_fwd = CTR_NEW;
      s1_lim_fwd = reg_lim;
    end
    s2_ctr_fwd = s2_ctr;
    s2_lim_fwd = s2_lim;
    if (s3_we && s3_ptr == s2_ptr) s2_ctr_fwd = s3_wdata;
    if (reg_v && reg_ptr == s2_ptr) begin
      s2_ctr_fwd = CTR_NEW;
      s2_lim_fwd = reg_lim;
    end
  end

  // S3 compare: error on unallocated, free at match, else bump the counter
  always_comb begin
    s3_err   = vld_pipe[3] && !s3_ctr.alloc;
    s3_we    = vld_pipe[3] && s3_ctr.alloc && !(reg_v && reg_ptr == s3_ptr);
    s3_free  = s3_we && (s3_ctr.cnt == s3_lim);
    s3_wdata = s3_free ? CTR_FREE : '{alloc: 1'b1, cnt: s3_ctr.cnt + 1'b1};
  end

  // Release pipeline S0 -> S1 -> S2 -> S3
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      s1_ptr   <= '0;
      s2_ptr   <= '0;
      s3_ptr   <= '0;
      s2_ctr   <= '0;
      s3_ctr   <= '0;
      s2_lim   <= '0;
      s3_lim   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], gnt_any};
      s1_ptr   <= gnt_ptr;
      s2_ptr   <= s1_ptr;
      s2_ctr   <= s1_ctr_fwd;
      s2_lim   <= s1_lim_fwd;
      s3_ptr   <= s2_ptr;
      s3_ctr   <= s2_ctr_fwd;
      s3_lim   <= s2_lim_fwd;
    end
  end

  // Error pulse for releases of unallocated buffers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rel_err_valid <= 1'b0;
      rel_err_ptr   <= '0;
    end else begin
      rel_err_valid <= s3_err;
      rel_err_ptr   <= s3_err ? s3_ptr : '0;
    end
  end

  assign o_push = s3_free;
  assign o_pop  = rel_buf_valid && rel_buf_ready;

  // Output FIFO storage (first-word-fall-through)
  always_ff @(posedge clk) begin
    if (o_push) omem[o_wr] <= s3_ptr;
  end

  // Output FIFO pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_wr  <= '0;
      o_rd  <= '0;
      o_cnt <= '0;
    end else begin
      o_wr  <= o_wr + OAW'(o_push);
      o_rd  <= o_rd + OAW'(o_pop);
      o_cnt <= o_cnt + OCW'(o_push) - OCW'(o_pop);
    end
  end

  assign rel_buf_valid = (o_cnt != '0);
  assign rel_buf_ptr   = rel_buf_valid ? omem[o_rd] : '0;

`ifndef SYNTHESIS
  // A zero-read registration must not be offered while the FIFO is full
  a_zfifo_no_ovf: assert property (@(posedge clk) disable iff (!rstn)
    !(read_count_valid && read_count == '0 && zfifo_full));
`endif

endmodule

// File: tb/tb_edit_mem_buf_release_mc.sv
// Directed bench for edit_mem_buf_release_mc with a reference model of the
// buffer table (expected reads, releases seen, allocated) and a scoreboard.
module tb_edit_mem_buf_release_mc;
  localparam int BW = 6, RW = 4, NCH = 4, OD = 4;

  logic clk = 1'b0, rstn = 1'b0;
  logic read_count_valid = 1'b0;
  logic [BW-1:0] read_count_buf_ptr = '0;
  logic [RW-1:0] read_count = '0;
  logic zfifo_full;
  logic [NCH-1:0] rel_req_valid, rel_req_ready;
  logic [NCH*BW-1:0] rel_req_ptr;
  logic rel_buf_valid, rel_buf_ready = 1'b1;
  logic [BW-1:0] rel_buf_ptr;
  logic rel_err_valid;
  logic [BW-1:0] rel_err_ptr;

  always #5 clk = ~clk;

  edit_mem_buf_release_mc #(.BPTR_NBITS(BW), .RC_NBITS(RW), .NUM_CH(NCH),
                            .ZFIFO_DEPTH(4), .OUT_DEPTH(OD)) dut (
    .clk(clk), .rstn(rstn),
    .read_count_valid(read_count_valid), .read_count_buf_ptr(read_count_buf_ptr),
    .read_count(read_count), .zfifo_full(zfifo_full),
    .rel_req_valid(rel_req_valid), .rel_req_ptr(rel_req_ptr), .rel_req_ready(rel_req_ready),
    .rel_buf_valid(rel_buf_valid), .rel_buf_ptr(rel_buf_ptr), .rel_buf_ready(rel_buf_ready),
    .rel_err_valid(rel_err_valid), .rel_err_ptr(rel_err_ptr));

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: buffer table plus expected output queues
  int  m_need[64], m_seen[64];
  bit  m_alloc[64];
  int  exp_free_q[$], exp_err_q[$];
  int  free_ptr_log[$], free_cyc_log[$], err_ptr_log[$], err_cyc_log[$];
  int  gnt_ch_log[$], gnt_cyc_log[$], gnt_ptr_log[$];
  int  reg_cyc;

  // Per-channel release queues feeding the request driver
  logic [BW-1:0] chq[NCH][16];
  int ch_hd[NCH], ch_tl[NCH];

  task automatic clear_logs();
    free_ptr_log.delete(); free_cyc_log.delete();
    err_ptr_log.delete();  err_cyc_log.delete();
    gnt_ch_log.delete();   gnt_cyc_log.delete(); gnt_ptr_log.delete();
  endtask

  // Model update and output comparison, sampled mid-cycle
  always @(negedge clk) begin
    int p;
    if (rstn) begin
      if (read_count_valid) begin
        p = int'(read_count_buf_ptr);
        m_need[p] = int'(read_count); m_seen[p] = 0;
        m_alloc[p] = (read_count != 0);
        if (read_count == 0) exp_free_q.push_back(p);
        reg_cyc = cyc;
      end
      chk("ready_onehot", int'($onehot0(rel_req_ready)), 1);
      chk("ready_needs_valid", int'(rel_req_ready & ~rel_req_valid), 0);
      for (int i = 0; i < NCH; i++) begin
        if (rel_req_valid[i] && rel_req_ready[i]) begin
          p = int'(rel_req_ptr[i*BW +: BW]);
          gnt_ch_log.push_back(i); gnt_cyc_log.push_back(cyc); gnt_ptr_log.push_back(p);
          if (!m_alloc[p]) exp_err_q.push_back(p);
          else begin
            m_seen[p]++;
            if (m_seen[p] == m_need[p]) begin
              m_alloc[p] = 1'b0;
              exp_free_q.push_back(p);
            end
          end
        end
      end
      if (rel_buf_valid && rel_buf_ready) begin
        if (exp_free_q.size() == 0) chk("unexpected_free", int'(rel_buf_ptr), -1);
        else chk("free_ptr", int'(rel_buf_ptr), exp_free_q.pop_front());
        free_ptr_log.push_back(int'(rel_buf_ptr)); free_cyc_log.push_back(cyc);
      end
      if (rel_err_valid) begin
        if (exp_err_q.size() == 0) chk("unexpected_err", int'(rel_err_ptr), -1);
        else chk("err_ptr", int'(rel_err_ptr), exp_err_q.pop_front());
        err_ptr_log.push_back(int'(rel_err_ptr)); err_cyc_log.push_back(cyc);
      end
    end
  end

  // Request driver: holds each channel's head pointer until it is granted
  initial begin
    logic [NCH-1:0] acc;
    rel_req_valid = '0;
    rel_req_ptr   = '0;
    for (int i = 0; i < NCH; i++) begin ch_hd[i] = 0; ch_tl[i] = 0; end
    forever begin
      @(negedge clk);
      acc = rel_req_valid & rel_req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < NCH; i++) begin
        if (acc[i] && ch_hd[i] != ch_tl[i]) ch_hd[i]++;
        if (ch_hd[i] != ch_tl[i]) begin
          rel_req_valid[i] = 1'b1;
          rel_req_ptr[i*BW +: BW] = chq[i][ch_hd[i] % 16];
        end else begin
          rel_req_valid[i] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic enq(input int ch, input int p);
    chq[ch][ch_tl[ch] % 16] = BW'(p);
    ch_tl[ch]++;
  endtask

  task automatic reg_buf(input int p, input int r);
    read_count_valid = 1'b1; read_count_buf_ptr = BW'(p); read_count = RW'(r);
    tick();
    read_count_valid = 1'b0;
  endtask

  function automatic bit ch_pending();
    bit b = 1'b0;
    for (int i = 0; i < NCH; i++) if (ch_hd[i] != ch_tl[i]) b = 1'b1;
    return b;
  endfunction

  // Bounded wait until all stimulus and expectations are consumed
  task automatic drain(input string tag);
    int n = 0;
    while ((ch_pending() || exp_free_q.size() != 0 || exp_err_q.size() != 0) && n < 100) begin
      tick(); n++;
    end
    chk({tag, "_drain_in_time"}, int'(n < 100), 1);
    repeat (8) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, int'(rel_req_ready), 0);
    chk({tag, "_buf_valid"}, int'(rel_buf_valid), 0);
    chk({tag, "_buf_ptr"},   int'(rel_buf_ptr), 0);
    chk({tag, "_err_valid"}, int'(rel_err_valid), 0);
    chk({tag, "_err_ptr"},   int'(rel_err_ptr), 0);
    chk({tag, "_zfifo_full"}, int'(zfifo_full), 0);
  endtask

  // Three releases of a 3-read buffer free it exactly 4 cycles after the last grant
  task automatic test_basic(input string tag);
    clear_logs();
    reg_buf(5, 3);
    enq(0, 5); enq(0, 5); enq(0, 5);
    drain(tag);
    chk({tag, "_grants"}, gnt_cyc_log.size(), 3);
    chk({tag, "_frees"}, free_ptr_log.size(), 1);
    if (free_ptr_log.size() == 1 && gnt_cyc_log.size() == 3) begin
      chk({tag, "_free_ptr"}, free_ptr_log[0], 5);
      chk({tag, "_latency"}, free_cyc_log[0] - gnt_cyc_log[2], 4);
    end
  endtask

  int exp_order[6] = '{13, 10, 14, 11, 15, 12};
  int exp_rr[4]    = '{1, 2, 3, 0};

  initial begin
    int w;
    repeat (3) tick();
    check_outputs_zero("reset");
    rstn = 1'b1;
    repeat (3) tick();

    test_basic("t1");

    // Zero-read buffer releases itself
    clear_logs();
    reg_buf(9, 0);
    drain("t2");
    chk("t2_grants", gnt_cyc_log.size(), 0);
    chk("t2_frees", free_ptr_log.size(), 1);
    if (free_ptr_log.size() == 1) begin
      chk("t2_free_ptr", free_ptr_log[0], 9);
      chk("t2_latency", free_cyc_log[0] - reg_cyc, 6);
    end

    // Four channels hit one buffer together; rr pointer sits at ch1 after t1
    clear_logs();
    reg_buf(2, 4);
    for (int i = 0; i < NCH; i++) enq(i, 2);
    drain("t3");
    chk("t3_grants", gnt_ch_log.size(), 4);
    if (gnt_ch_log.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t3_rr_ch%0d", i), gnt_ch_log[i], exp_rr[i]);
        chk($sformatf("t3_rr_cyc%0d", i), gnt_cyc_log[i] - gnt_cyc_log[0], i);
      end
    chk("t3_frees", free_ptr_log.size(), 1);
    if (free_ptr_log.size() == 1) chk("t3_free_ptr", free_ptr_log[0], 2);

    // Backpressure: only OUT_DEPTH grants while the allocator stalls
    for (int p = 10; p < 16; p++) reg_buf(p, 1);
    clear_logs();
    rel_buf_ready = 1'b0;
    for (int p = 10; p < 13; p++) enq(0, p);
    for (int p = 13; p < 16; p++) enq(1, p);
    repeat (20) tick();
    chk("t4_grants_stalled", gnt_cyc_log.size(), OD);
    chk("t4_buf_valid_held", int'(rel_buf_valid), 1);
    chk("t4_no_pop", free_ptr_log.size(), 0);
    rel_buf_ready = 1'b1;
    drain("t4");
    chk("t4_frees", free_ptr_log.size(), 6);
    if (free_ptr_log.size() == 6)
      for (int i = 0; i < 6; i++) chk($sformatf("t4_order%0d", i), free_ptr_log[i], exp_order[i]);

    // Release of an already-freed buffer raises an error, no free
    clear_logs();
    reg_buf(7, 1);
    enq(2, 7);
    drain("t5a");
    chk("t5_first_free", free_ptr_log.size(), 1);
    clear_logs();
    enq(2, 7);
    drain("t5b");
    chk("t5_errs", err_ptr_log.size(), 1);
    chk("t5_no_free", free_ptr_log.size(), 0);
    if (err_ptr_log.size() == 1 && gnt_cyc_log.size() == 1) begin
      chk("t5_err_ptr", err_ptr_log[0], 7);
      chk("t5_err_latency", err_cyc_log[0] - gnt_cyc_log[0], 4);
    end

    // Reset in the middle of a burst
    reg_buf(20, 8);
    reg_buf(21, 8);
    for (int k = 0; k < 4; k++) begin enq(0, 20); enq(1, 21); end
    repeat (3) tick();
    w = gnt_cyc_log.size();
    rstn = 1'b0;
    for (int i = 0; i < NCH; i++) ch_hd[i] = ch_tl[i];
    exp_free_q.delete(); exp_err_q.delete();
    tick();
    check_outputs_zero("t6_in_reset");
    tick();
    rstn = 1'b1;
    repeat (2) tick();
    chk("t6_burst_started", int'(w > 0), 1);
    test_basic("t6");

    chk("end_free_q_empty", exp_free_q.size(), 0);
    chk("end_err_q_empty", exp_err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
